// File: rtl/resp_arbiter.sv
// Response arbiter: merges a one-entry cc register and a 4-deep RAM dump FIFO onto one UART
// transmitter, round-robin on ties, one byte in flight at a time.
module resp_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cc_send,
  input  logic [7:0] cc_data,
  input  logic       ram_trmt,
  input  logic [7:0] ram_data,
  input  logic       flush,
  input  logic       resp_sent,
  output logic       send_resp,
  output logic [7:0] resp_data,
  output logic       ram_rdy,
  output logic       busy,
  output logic       grant_src,
  output logic       cc_ovf,
  output logic       ram_ovf
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e     r_state;
  logic       r_send;
  logic [7:0] r_resp;
  logic       r_src;
  logic       r_busy;

  logic       r_cc_pend;
  logic [7:0] r_cc_data;
  logic       r_cc_ovf;

  logic [7:0] r_fifo [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic       r_ram_ovf;

  logic w_idle;
  logic w_full;
  logic w_ram_pend;
  logic w_gnt_ram;
  logic w_gnt_cc;
  logic w_push;

  // Flush masks the FIFO as a grant candidate so it never pops on the flushing edge.
  assign w_idle     = (r_state == StIdle);
  assign w_full     = (r_count == 3'd4);
  assign w_ram_pend = (r_count != 3'd0) && !flush;
  assign w_gnt_ram  = w_idle && w_ram_pend && (!r_cc_pend || !r_src);
  assign w_gnt_cc   = w_idle && r_cc_pend && (!w_ram_pend || r_src);
  assign w_push     = ram_trmt && !w_full && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_send  <= 1'b0;
      r_resp  <= 8'h00;
      r_src   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_send <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_gnt_ram || w_gnt_cc) begin
            r_state <= StBusy;
            r_busy  <= 1'b1;
            r_send  <= 1'b1;
            r_src   <= w_gnt_ram;
            r_resp  <= w_gnt_ram ? r_fifo[r_rptr] : r_cc_data;
          end
        end
        StBusy: begin
          if (resp_sent) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // A new cc byte is accepted on the very edge the held one is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc_pend <= 1'b0;
      r_cc_data <= 8'h00;
      r_cc_ovf  <= 1'b0;
    end else if (cc_send) begin
      if (r_cc_pend && !w_gnt_cc) begin
        r_cc_ovf <= 1'b1;
      end else begin
        r_cc_pend <= 1'b1;
        r_cc_data <= cc_data;
      end
    end else if (w_gnt_cc) begin
      r_cc_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= ram_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= 2'd0;
      r_rptr    <= 2'd0;
      r_count   <= 3'd0;
      r_ram_ovf <= 1'b0;
    end else if (flush) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push)    r_wptr <= r_wptr + 2'd1;
      if (w_gnt_ram) r_rptr <= r_rptr + 2'd1;
      if (ram_trmt && w_full) r_ram_ovf <= 1'b1;
      if (w_push && !w_gnt_ram)      r_count <= r_count + 3'd1;
      else if (!w_push && w_gnt_ram) r_count <= r_count - 3'd1;
    end
  end

  assign send_resp = r_send;
  assign resp_data = r_resp;
  assign grant_src = r_src;
  assign busy      = r_busy;
  assign ram_rdy   = !w_full;
  assign cc_ovf    = r_cc_ovf;
  assign ram_ovf   = r_ram_ovf;

endmodule
